// File: rtl/usb_transmitter_pkg.sv
// Shared definitions for the full-speed USB transmit path: line-state
// encodings, SYNC pattern, bit-stuff limit, EOP length and the transmitter
// state encoding. State names carry a TX_ prefix so they can coexist with the
// receiver's states in the same scope.
package usb_transmitter_pkg;

    // Line states as {D+, D-}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam logic [7:0] SYNC_PATTERN = 8'h80;
    localparam logic [2:0] STUFF_LIMIT  = 3'd6;
    localparam int         EOP_SE0_BITS = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SYNC,
        TX_DATA,
        TX_EOP_SE0,
        TX_EOP_J,
        TX_GAP
    } tx_state_t;

endpackage

// File: rtl/usb_nrzi_encoder.sv
// NRZI line encoder with consecutive-ones tracking.
// Holds the current line level (J or K, or SE0 during EOP) and counts
// consecutive 1 bits so the parent knows when a stuff bit is due.
// Ports:
//   clock48, reset_n  - clock and asynchronous active-low reset
//   i_strobe          - a new bit time starts on this edge
//   i_bit             - value of the bit starting now (0 toggles, 1 holds)
//   i_se0             - drive SE0 for this bit time instead of data
//   o_line            - current line state {D+, D-}
//   o_stuff_needed    - six consecutive 1s are on the line; next bit must be a stuffed 0
module usb_nrzi_encoder
    import usb_transmitter_pkg::*;
(
    input  logic       clock48,
    input  logic       reset_n,
    input  logic       i_strobe,
    input  logic       i_bit,
    input  logic       i_se0,
    output logic [1:0] o_line,
    output logic       o_stuff_needed
);

    logic       r_level_j;
    logic       r_se0;
    logic [2:0] r_ones;

    always_ff @(posedge clock48 or negedge reset_n) begin
        if (!reset_n) begin
            r_level_j <= 1'b1;
            r_se0     <= 1'b0;
            r_ones    <= '0;
        end else if (i_strobe) begin
            if (i_se0) begin
                r_se0  <= 1'b1;
                r_ones <= '0;
            end else if (r_se0) begin
                // First bit after SE0 is the EOP J; line returns to idle level.
                r_se0     <= 1'b0;
                r_level_j <= 1'b1;
                r_ones    <= '0;
            end else if (i_bit) begin
                r_ones <= r_ones + 3'd1;
            end else begin
                r_level_j <= ~r_level_j;
                r_ones    <= '0;
            end
        end
    end

    always_comb begin
        o_line = LINE_K;
        if (r_se0)
            o_line = LINE_SE0;
        else if (r_level_j)
            o_line = LINE_J;
    end

    assign o_stuff_needed = (r_ones == STUFF_LIMIT);

endmodule

// File: rtl/usb_transmitter.sv
// Full-speed USB packet transmitter. Serialises a byte stream into
// SYNC + NRZI data with bit stuffing + EOP on the D+/D- pair, then holds
// the driver released for an idle gap before the next packet.
// Ports:
//   clock48, reset_n           - 48 MHz clock, asynchronous active-low reset
//   tx_valid/tx_data/tx_last   - byte offered by packet logic (LSB first)
//   tx_ready                   - one-cycle pulse, byte consumed on this edge
//   tx_busy                    - packet in progress (SYNC through idle gap)
//   tx_error                   - one-cycle pulse on underrun
//   usb_d_p_out/usb_d_n_out    - driven line levels (J while released)
//   usb_oe                     - pad output enable
//
// state      | meaning
// TX_IDLE    | released, waiting for tx_valid
// TX_SYNC    | sending 8'h80 LSB first
// TX_DATA    | sending data bits and stuff bits
// TX_EOP_SE0 | SE0 for EOP_SE0_BITS bit times
// TX_EOP_J   | one bit time of J
// TX_GAP     | released, busy for IDLE_GAP_BITS bit times
module usb_transmitter #(
    parameter int BIT_CLOCKS    = 4,
    parameter int IDLE_GAP_BITS = 2
) (
    input  logic       clock48,
    input  logic       reset_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_error,
    output logic       usb_d_p_out,
    output logic       usb_d_n_out,
    output logic       usb_oe
);
    import usb_transmitter_pkg::*;

    localparam int PW = (BIT_CLOCKS > 1) ? $clog2(BIT_CLOCKS) : 1;

    tx_state_t    r_state, w_state_next;
    logic [PW-1:0] r_phase;
    logic [7:0]   r_shift, w_shift_next;
    logic [3:0]   r_bit_cnt, w_bit_cnt_next;
    logic         r_last, w_last_next;
    logic         r_stuff, w_stuff_next;
    logic         r_done, w_done_next;

    logic         w_bit_end;
    logic         w_strobe, w_bit, w_se0;
    logic         w_stuff_needed;
    logic [1:0]   w_line;
    logic         w_load, w_done_now;
    logic [7:0]   w_src_byte;
    logic [3:0]   w_src_cnt;

    assign w_bit_end = (r_phase == PW'(BIT_CLOCKS - 1));

    usb_nrzi_encoder u_nrzi (
        .clock48        (clock48),
        .reset_n        (reset_n),
        .i_strobe       (w_strobe),
        .i_bit          (w_bit),
        .i_se0          (w_se0),
        .o_line         (w_line),
        .o_stuff_needed (w_stuff_needed)
    );

    always_ff @(posedge clock48 or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= TX_IDLE;
            r_phase   <= '0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_last    <= 1'b0;
            r_stuff   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_phase   <= (r_state == TX_IDLE || w_bit_end) ? '0 : r_phase + PW'(1);
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_last    <= w_last_next;
            r_stuff   <= w_stuff_next;
            r_done    <= w_done_next;
        end
    end

    // r_bit_cnt: bits already started from the current byte (SYNC or data),
    // or elapsed bit times in EOP_SE0/GAP. r_stuff marks a stuff bit on the line.
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_last_next    = r_last;
        w_stuff_next   = r_stuff;
        w_done_next    = r_done;
        w_strobe       = 1'b0;
        w_bit          = 1'b1;
        w_se0          = 1'b0;
        tx_ready       = 1'b0;
        tx_error       = 1'b0;
        w_load         = 1'b0;
        w_done_now     = 1'b0;
        w_src_byte     = r_shift;
        w_src_cnt      = r_bit_cnt;

        case (r_state)
            TX_IDLE: begin
                if (tx_valid) begin
                    tx_ready       = 1'b1;
                    w_shift_next   = tx_data;
                    w_last_next    = tx_last;
                    w_done_next    = 1'b0;
                    w_stuff_next   = 1'b0;
                    w_strobe       = 1'b1;
                    w_bit          = SYNC_PATTERN[0];
                    w_bit_cnt_next = 4'd1;
                    w_state_next   = TX_SYNC;
                end
            end
            TX_SYNC: begin
                if (w_bit_end) begin
                    w_strobe = 1'b1;
                    if (r_bit_cnt == 4'd8) begin
                        w_bit          = r_shift[0];
                        w_shift_next   = r_shift >> 1;
                        w_bit_cnt_next = 4'd1;
                        w_state_next   = TX_DATA;
                    end else begin
                        w_bit          = SYNC_PATTERN[r_bit_cnt[2:0]];
                        w_bit_cnt_next = r_bit_cnt + 4'd1;
                    end
                end
            end
            TX_DATA: begin
                if (w_bit_end) begin
                    // Byte boundary is taken at the end of data bit 7 itself,
                    // even when a stuff bit follows it.
                    if (!r_stuff && r_bit_cnt == 4'd8) begin
                        if (r_last) begin
                            w_done_now = 1'b1;
                        end else if (tx_valid) begin
                            tx_ready    = 1'b1;
                            w_load      = 1'b1;
                            w_last_next = tx_last;
                        end else begin
                            tx_error   = 1'b1;
                            w_done_now = 1'b1;
                        end
                    end
                    w_src_byte = w_load ? tx_data : r_shift;
                    w_src_cnt  = w_load ? 4'd0 : r_bit_cnt;
                    w_strobe   = 1'b1;
                    if (w_stuff_needed) begin
                        w_bit          = 1'b0;
                        w_stuff_next   = 1'b1;
                        w_shift_next   = w_src_byte;
                        w_bit_cnt_next = w_src_cnt;
                        w_done_next    = r_done | w_done_now;
                    end else if (r_done || w_done_now) begin
                        w_se0          = 1'b1;
                        w_stuff_next   = 1'b0;
                        w_bit_cnt_next = 4'd1;
                        w_state_next   = TX_EOP_SE0;
                    end else begin
                        w_bit          = w_src_byte[0];
                        w_shift_next   = w_src_byte >> 1;
                        w_bit_cnt_next = w_src_cnt + 4'd1;
                        w_stuff_next   = 1'b0;
                    end
                end
            end
            TX_EOP_SE0: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == 4'(EOP_SE0_BITS)) begin
                        w_strobe     = 1'b1;
                        w_state_next = TX_EOP_J;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 4'd1;
                    end
                end
            end
            TX_EOP_J: begin
                if (w_bit_end) begin
                    w_bit_cnt_next = 4'd1;
                    w_state_next   = TX_GAP;
                end
            end
            TX_GAP: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == 4'(IDLE_GAP_BITS)) begin
                        w_bit_cnt_next = 4'd0;
                        w_state_next   = TX_IDLE;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 4'd1;
                    end
                end
            end
            default: w_state_next = TX_IDLE;
        endcase
    end

    assign usb_oe  = (r_state != TX_IDLE) && (r_state != TX_GAP);
    assign tx_busy = (r_state != TX_IDLE);
    assign {usb_d_p_out, usb_d_n_out} = usb_oe ? w_line : LINE_J;

endmodule

// File: tb/tb_usb_transmitter.sv
module tb_usb_transmitter;

    logic       clock48;
    logic       reset_n;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_error;
    logic       usb_d_p_out;
    logic       usb_d_n_out;
    logic       usb_oe;

    usb_transmitter #(.BIT_CLOCKS(4), .IDLE_GAP_BITS(2)) dut (
        .clock48     (clock48),
        .reset_n     (reset_n),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_last     (tx_last),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .tx_error    (tx_error),
        .usb_d_p_out (usb_d_p_out),
        .usb_d_n_out (usb_d_n_out),
        .usb_oe      (usb_oe)
    );

    initial clock48 = 1'b0;
    always #5 clock48 = ~clock48;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] q_sym[$];
    int         q_oe[$];
    int         q_busy[$];

    int oe_run = 0, busy_run = 0, gap_run = 0;
    bit prev_oe = 0, prev_busy = 0, have_gap = 0;
    int n_ready = 0, n_err = 0, err_at = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: SYNC + data bits, stuff after every sixth 1, NRZI from J, then SE0 SE0 J.
    task automatic model_push(input logic [7:0] b0, input logic [7:0] b1, input int n);
        bit         raw[$];
        bit         st[$];
        logic [7:0] cur;
        logic [7:0] sync_byte;
        logic [1:0] lvl;
        int         ones;
        sync_byte = 8'h80;
        for (int i = 0; i < 8; i++) raw.push_back(sync_byte[i]);
        for (int k = 0; k < n; k++) begin
            cur = (k == 0) ? b0 : b1;
            for (int i = 0; i < 8; i++) raw.push_back(cur[i]);
        end
        ones = 0;
        foreach (raw[i]) begin
            st.push_back(raw[i]);
            if (raw[i]) ones++; else ones = 0;
            if (ones == 6) begin
                st.push_back(1'b0);
                ones = 0;
            end
        end
        lvl = 2'b10;
        foreach (st[i]) begin
            if (!st[i]) lvl = (lvl == 2'b10) ? 2'b01 : 2'b10;
            q_sym.push_back(lvl);
        end
        q_sym.push_back(2'b00);
        q_sym.push_back(2'b00);
        q_sym.push_back(2'b10);
        q_oe.push_back(4 * (st.size() + 3));
        q_busy.push_back(4 * (st.size() + 3) + 8);
    endtask

    // Monitor: compares the line every cycle against the scoreboard, pops one
    // symbol per 4 cycles, checks enable/busy lengths when they fall.
    initial begin
        int e;
        forever begin
            @(negedge clock48);
            if (!reset_n) begin
                q_sym.delete(); q_oe.delete(); q_busy.delete();
                oe_run = 0; busy_run = 0; gap_run = 0;
                prev_oe = 0; prev_busy = 0; have_gap = 0;
            end else begin
                if (usb_oe) begin
                    if (!prev_oe && have_gap) check_eq("gap_min8", gap_run >= 8, 1);
                    oe_run++;
                    if (q_sym.size() == 0) begin
                        check_eq("sym_extra", q_sym.size(), 1);
                    end else begin
                        check_eq("line", {usb_d_p_out, usb_d_n_out}, q_sym[0]);
                        if (oe_run % 4 == 0) void'(q_sym.pop_front());
                    end
                end else begin
                    if (prev_oe) begin
                        e = (q_oe.size() > 0) ? q_oe.pop_front() : -1;
                        check_eq("oe_len", oe_run, e);
                        oe_run = 0; gap_run = 0; have_gap = 1;
                    end
                    check_eq("idle_j", {usb_d_p_out, usb_d_n_out}, 2'b10);
                    gap_run++;
                end
                if (tx_busy) begin
                    busy_run++;
                end else if (prev_busy) begin
                    e = (q_busy.size() > 0) ? q_busy.pop_front() : -1;
                    check_eq("busy_len", busy_run, e);
                    busy_run = 0;
                end
                if (tx_ready) n_ready++;
                if (tx_error) begin
                    n_err++;
                    err_at = oe_run;
                end
                prev_oe = usb_oe;
                prev_busy = tx_busy;
            end
        end
    end

    task automatic wait_ready();
        bit ok = 0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clock48);
            if (tx_ready) ok = 1;
            @(posedge clock48);
            #1;
        end
        check_eq("ready_seen", ok, 1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clock48);
            if (!tx_busy) ok = 1;
        end
        check_eq("idle_reached", ok, 1);
        check_eq("sym_left", q_sym.size(), 0);
        repeat (2) @(posedge clock48);
        #1;
    endtask

    task automatic send_pkt(input logic [7:0] d0, input logic [7:0] d1, input int n,
                            input bit underrun, input bit keep_valid);
        model_push(d0, d1, n);
        for (int k = 0; k < n; k++) begin
            tx_valid = 1'b1;
            tx_data  = (k == 0) ? d0 : d1;
            tx_last  = (k == n - 1) && !underrun;
            wait_ready();
            if (k == 0) begin
                check_eq("lat_oe", usb_oe, 1);
                check_eq("lat_k", {usb_d_p_out, usb_d_n_out}, 2'b01);
            end
        end
        if (!keep_valid) tx_valid = 1'b0;
    endtask

    task automatic run_single(input string tag, input logic [7:0] d);
        n_ready = 0; n_err = 0;
        send_pkt(d, 8'h00, 1, 0, 0);
        wait_idle();
        check_eq({tag, "_ready"}, n_ready, 1);
        check_eq({tag, "_err"}, n_err, 0);
    endtask

    initial begin
        reset_n  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        #3;
        check_eq("rst_oe", usb_oe, 0);
        check_eq("rst_line", {usb_d_p_out, usb_d_n_out}, 2'b10);
        check_eq("rst_busy", tx_busy, 0);
        check_eq("rst_ready", tx_ready, 0);
        check_eq("rst_err", tx_error, 0);
        #20 reset_n = 1'b1;
        @(posedge clock48);
        #1;

        run_single("single00", 8'h00);
        run_single("stuffFF", 8'hFF);
        run_single("stuffFC", 8'hFC);

        // stuff bit right after bit 7 of a non-final byte
        n_ready = 0; n_err = 0;
        send_pkt(8'hFC, 8'h01, 2, 0, 0);
        wait_idle();
        check_eq("boundary_ready", n_ready, 2);
        check_eq("boundary_err", n_err, 0);

        // underrun
        n_ready = 0; n_err = 0; err_at = -1;
        send_pkt(8'hA5, 8'h00, 1, 1, 0);
        wait_idle();
        check_eq("under_ready", n_ready, 1);
        check_eq("under_err", n_err, 1);
        check_eq("under_err_pos", err_at, 64);

        // back-to-back with tx_valid held high
        n_ready = 0; n_err = 0;
        send_pkt(8'h2D, 8'h00, 1, 0, 1);
        send_pkt(8'hC3, 8'h00, 1, 0, 0);
        wait_idle();
        check_eq("b2b_ready", n_ready, 2);
        check_eq("b2b_err", n_err, 0);

        // reset mid-DATA
        model_push(8'h55, 8'h00, 1);
        tx_valid = 1'b1; tx_data = 8'h55; tx_last = 1'b1;
        wait_ready();
        tx_valid = 1'b0;
        repeat (40) @(posedge clock48);
        #2 reset_n = 1'b0;
        #1;
        check_eq("midrst_oe", usb_oe, 0);
        check_eq("midrst_line", {usb_d_p_out, usb_d_n_out}, 2'b10);
        check_eq("midrst_busy", tx_busy, 0);
        repeat (2) @(posedge clock48);
        #3 reset_n = 1'b1;
        @(posedge clock48);
        #1;
        run_single("after_rst", 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
